// File: rtl/psubsb_seq.sv
// Sequential packed saturating subtract of four signed 4-bit lanes, one lane per cycle.
// Optional per-lane saturation flags are enabled with `define PSUBSB_SATFLAGS_EN.
module psubsb_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Diff
`ifdef PSUBSB_SATFLAGS_EN
  ,
  output logic [3:0]  sat_flags
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [1:0]  lane;
  logic [15:0] a_reg;
  logic [15:0] b_reg;

  logic [3:0]  a_lane;
  logic [3:0]  b_lane;
  logic [3:0]  raw;
  logic        ovf;
  logic [3:0]  res;

  // Shared lane subtractor: overflow only possible when operand signs differ.
  always_comb begin
    a_lane = a_reg[{lane, 2'b00} +: 4];
    b_lane = b_reg[{lane, 2'b00} +: 4];
    raw    = a_lane - b_lane;
    ovf    = (a_lane[3] ^ b_lane[3]) & (raw[3] ^ a_lane[3]);
    res    = ovf ? (a_lane[3] ? 4'b1000 : 4'b0111) : raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lane  <= 2'd0;
      a_reg <= 16'h0000;
      b_reg <= 16'h0000;
      Diff  <= 16'h0000;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef PSUBSB_SATFLAGS_EN
      sat_flags <= 4'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            lane  <= 2'd0;
            busy  <= 1'b1;
            state <= CALC;
`ifdef PSUBSB_SATFLAGS_EN
            sat_flags <= 4'h0;
`endif
          end
        end
        CALC: begin
          Diff[{lane, 2'b00} +: 4] <= res;
`ifdef PSUBSB_SATFLAGS_EN
          if (ovf) sat_flags[lane] <= 1'b1;
`endif
          // Counter wraps 3->0 exactly on the edge that leaves CALC.
          lane <= lane + 2'd1;
          if (lane == 2'd3) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
